// File: rtl/uart_pkg.sv
// Shared UART definitions: rate codes, frame constants, TX state encoding
// and the elaboration-time baud divisor helper used by both TX and RX.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam logic [1:0] RATE_9600   = 2'd0;
    localparam logic [1:0] RATE_19200  = 2'd1;
    localparam logic [1:0] RATE_38400  = 2'd2;
    localparam logic [1:0] RATE_115200 = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Rounded clk_freq/baud so both ends agree on the bit period.
    function automatic int unsigned baud_div(
        input int unsigned clk_freq,
        input logic [1:0]  rate
    );
        int unsigned baud;
        case (rate)
            RATE_9600:   baud = 9600;
            RATE_19200:  baud = 19200;
            RATE_38400:  baud = 38400;
            default:     baud = 115200;
        endcase
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled, pulses o_tick on the
// last cycle of each period. Ports: clk, reset (sync, low), i_en, i_div, o_tick.
module uart_baud_tick #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == i_div - CNT_W'(1));

    // Held at zero while disabled so each enable starts a full period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and selectable baud rate.
// Ports: clk, reset (sync, low), iRate, iData, iValid, oReady, oTX, oBusy, oDone.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned STOP_BITS = 1,
    parameter int          CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] iRate,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oTX,
    output logic       oBusy,
    output logic       oDone
);

    localparam logic [CNT_W-1:0] DIV0 = CNT_W'(baud_div(CLK_FREQ, RATE_9600));
    localparam logic [CNT_W-1:0] DIV1 = CNT_W'(baud_div(CLK_FREQ, RATE_19200));
    localparam logic [CNT_W-1:0] DIV2 = CNT_W'(baud_div(CLK_FREQ, RATE_38400));
    localparam logic [CNT_W-1:0] DIV3 = CNT_W'(baud_div(CLK_FREQ, RATE_115200));

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [1:0]       r_rate;
    logic [7:0]       r_shreg;
    logic [2:0]       r_bit;
    logic             r_stop;
    logic             r_tx;
    logic             r_done;
    logic             r_en;
    logic [CNT_W-1:0] w_div;
    logic             w_tick;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_stop_last;
    logic             w_tx_nxt;
    logic             w_done_nxt;

    assign oReady      = (r_state == IDLE) && r_en;
    assign oBusy       = (r_state != IDLE);
    assign oTX         = r_tx;
    assign oDone       = r_done;
    assign w_accept    = iValid && oReady;
    assign w_last_bit  = (r_bit == 3'(DATA_BITS - 1));
    assign w_stop_last = (STOP_BITS == 1) || r_stop;

    // Rate is latched at accept, so mid-frame iRate changes are ignored.
    always_comb begin
        case (r_rate)
            RATE_9600:  w_div = DIV0;
            RATE_19200: w_div = DIV1;
            RATE_38400: w_div = DIV2;
            default:    w_div = DIV3;
        endcase
    end

    uart_baud_tick #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_en   (r_state != IDLE),
        .i_div  (w_div),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // oTX/oDone are registered from the state, so the line lags the
    // state by one cycle and only moves at bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = 1'b1;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = START;
            end
            START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) w_state_nxt = DATA;
            end
            DATA: begin
                w_tx_nxt = r_shreg[0];
                if (w_tick && w_last_bit) w_state_nxt = STOP;
            end
            STOP: begin
                if (w_tick && w_stop_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en    <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_rate  <= 2'd0;
            r_shreg <= 8'd0;
            r_bit   <= 3'd0;
            r_stop  <= 1'b0;
        end else begin
            r_en   <= 1'b1;
            r_tx   <= w_tx_nxt;
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_shreg <= iData;
                r_rate  <= iRate;
                r_bit   <= 3'd0;
                r_stop  <= 1'b0;
            end
            if (r_state == DATA && w_tick) begin
                r_shreg <= {1'b0, r_shreg[7:1]};
                r_bit   <= w_last_bit ? 3'd0 : r_bit + 3'd1;
            end
            if (r_state == STOP && w_tick) begin
                r_stop <= !w_stop_last;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks line waveform cycle by cycle,
// handshake, oDone timing, rate latching and mid-frame reset.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] iRate;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;
    logic       oTX;
    logic       oBusy;
    logic       oDone;

    int n_chk = 0;
    int n_fail = 0;
    int done_tot = 0;

    // 1.152 MHz gives exact divisors 120/60/30/10 and short frames.
    uart_tx #(
        .CLK_FREQ  (1_152_000),
        .STOP_BITS (1),
        .CNT_W     (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .iRate  (iRate),
        .iData  (iData),
        .iValid (iValid),
        .oReady (oReady),
        .oTX    (oTX),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (oDone === 1'b1) done_tot++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic send(
        input logic [7:0] d,
        input logic [1:0] r,
        input bit         keep
    );
        int w = 0;
        iData  = d;
        iRate  = r;
        iValid = 1'b1;
        while (oReady !== 1'b1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (oReady !== 1'b1) chk("send.ready", 32'(oReady), 1);
        @(negedge clk);
        if (!keep) iValid = 1'b0;
    endtask

    // Receiver model: finds the falling start edge, then checks every
    // cycle of the frame plus the following idle cycle.
    task automatic cap(
        input  string       tag,
        input  int          div,
        input  logic [7:0]  exp,
        input  int          rate_n,
        input  logic [1:0]  rate_v,
        input  int          drop_n,
        output logic [7:0]  rx
    );
        int         waits = 0;
        int         err = 0;
        int         done_n = -1;
        int         done_c = 0;
        int         rdy_hi = 0;
        int         k;
        logic [9:0] mid = '0;
        logic [9:0] expv;
        expv = {1'b1, exp, 1'b0};
        rx = 8'h00;
        do begin
            @(negedge clk);
            waits++;
        end while (oTX !== 1'b0 && waits < 50);
        chk({tag, ".lat"}, waits, 1);
        if (oTX !== 1'b0) return;
        for (int n = 1; n <= 10 * div + 1; n++) begin
            if (n > 1) @(negedge clk);
            if (n == rate_n) iRate = rate_v;
            if (n == drop_n) iValid = 1'b0;
            if (n <= 10 * div) begin
                k = (n - 1) / div;
                if (oTX !== expv[k]) err++;
                if ((n - 1) % div == div / 2) mid[k] = oTX;
                if (n < 10 * div && oReady !== 1'b0) rdy_hi++;
            end else if (oTX !== 1'b1) begin
                err++;
            end
            if (oDone === 1'b1) begin
                done_c++;
                done_n = n;
            end
        end
        rx = mid[8:1];
        chk({tag, ".bits"}, 32'(mid), 32'(expv));
        chk({tag, ".wave"}, err, 0);
        chk({tag, ".done_at"}, done_n, 10 * div);
        chk({tag, ".done_cnt"}, done_c, 1);
        chk({tag, ".rdy_low"}, rdy_hi, 0);
    endtask

    logic [7:0] rx;
    logic [7:0] lb_tx [3];
    logic [7:0] lb_rx [$];
    int         d0;

    initial begin
        reset  = 1'b0;
        iRate  = 2'd0;
        iData  = 8'h00;
        iValid = 1'b0;

        chk("div9600",   uart_pkg::baud_div(100_000_000, 2'd0), 10417);
        chk("div19200",  uart_pkg::baud_div(100_000_000, 2'd1), 5208);
        chk("div38400",  uart_pkg::baud_div(100_000_000, 2'd2), 2604);
        chk("div115200", uart_pkg::baud_div(100_000_000, 2'd3), 868);

        repeat (2) @(negedge clk);
        chk("rst.tx",    32'(oTX), 1);
        chk("rst.busy",  32'(oBusy), 0);
        chk("rst.ready", 32'(oReady), 0);
        chk("rst.done",  32'(oDone), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel.ready", 32'(oReady), 1);
        chk("rel.tx",    32'(oTX), 1);
        chk("rel.busy",  32'(oBusy), 0);

        send(8'h31, 2'd0, 1'b0);
        chk("s9600.busy", 32'(oBusy), 1);
        cap("s9600", 120, 8'h31, 0, 2'd0, 0, rx);

        send(8'h32, 2'd3, 1'b1);
        iData = 8'h33;
        cap("b2b0", 10, 8'h32, 0, 2'd0, 0, rx);
        cap("b2b1", 10, 8'h33, 0, 2'd0, 1, rx);
        repeat (3) @(negedge clk);
        chk("b2b.idle", 32'(oBusy), 0);

        lb_tx[0] = 8'h4D;
        lb_tx[1] = 8'h35;
        lb_tx[2] = 8'h46;
        for (int i = 0; i < 3; i++) begin
            send(lb_tx[i], 2'd0, 1'b0);
            cap("lb", 120, lb_tx[i], 0, 2'd0, 0, rx);
            lb_rx.push_back(rx);
        end
        chk("lb.count", lb_rx.size(), 3);
        for (int i = 0; i < 3; i++) chk("lb.byte", 32'(lb_rx[i]), 32'(lb_tx[i]));

        send(8'hA5, 2'd1, 1'b0);
        cap("rchg", 60, 8'hA5, 180, 2'd3, 0, rx);
        send(8'h5A, 2'd3, 1'b0);
        cap("rnext", 10, 8'h5A, 0, 2'd0, 0, rx);

        send(8'hFF, 2'd3, 1'b0);
        repeat (53) @(negedge clk);
        chk("mrst.pre_busy", 32'(oBusy), 1);
        d0 = done_tot;
        reset = 1'b0;
        @(negedge clk);
        chk("mrst.tx",    32'(oTX), 1);
        chk("mrst.busy",  32'(oBusy), 0);
        chk("mrst.done",  32'(oDone), 0);
        chk("mrst.ready", 32'(oReady), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst.rel_ready", 32'(oReady), 1);
        repeat (120) @(negedge clk);
        chk("mrst.no_done", done_tot, d0);
        chk("mrst.idle_tx", 32'(oTX), 1);
        send(8'h00, 2'd3, 1'b0);
        cap("post", 10, 8'h00, 0, 2'd0, 0, rx);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: accepts bytes over a valid/ready handshake and serialises them LSB-first onto a single TX line at a runtime-selectable baud rate.
- Sits alongside the UART receive path in the top level. Its line output can loop back into the receiver pin for self-test, or drive the host link to echo or acknowledge received bytes.
- It shares baud-rate encoding with the receive side, so both ends agree on bit period.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- STOP_BITS, 1, number of stop bits (1 or 2).
- CNT_W, 16, bit-period counter width; must hold CLK_FREQ/9600.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- iRate  input  2  baud select: 0=9600, 1=19200, 2=38400, 3=115200.
- iData  input  8  byte to send; sampled on the accept edge.
- iValid  input  1  iData is valid.
- oReady  output  1  block can accept a byte this cycle.
- oTX  output  1  serial line; idles high.
- oBusy  output  1  a frame is in progress (state != IDLE).
- oDone  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low: while reset==0 at a rising edge, all state is cleared.
- Reset values: oTX=1, oReady=0 during reset and 1 from the first edge after release, oBusy=0, oDone=0, state=IDLE, counters=0, shift register=0.
- Divisor: DIV = round(CLK_FREQ/baud), computed at elaboration per rate. At 100 MHz: 10417, 5208, 2604, 868. Each bit lasts exactly DIV clk cycles.
- Accept: a byte is accepted on the rising edge where iValid && oReady. iData and iRate are latched on that edge.
  - iRate changes mid-frame have no effect until the next accept.
  - iData may change freely after the accept edge.
- oReady = (state==IDLE) && reset released. It is combinational from state; it does not depend on iValid.
- State machine (oTX registered):
  - IDLE: oTX=1. On accept -> START, bit counter cleared.
  - START: oTX=0 for DIV cycles -> DATA.
  - DATA: oTX=shreg[0] for DIV cycles per bit, shift right after each bit. After 8 bits -> STOP.
  - STOP: oTX=1 for STOP_BITS*DIV cycles. oDone=1 on the final cycle -> IDLE.
- Latency: oTX falls on the edge following the accept edge (1 cycle).
- Frame length: (1+8+STOP_BITS)*DIV cycles of start/data/stop. There is a minimum 1-cycle IDLE gap between frames, so back-to-back throughput is one byte per (10*DIV+1) cycles with STOP_BITS=1.
- iValid held high continuously: a new frame starts after each 1-cycle IDLE gap, with no dropped or duplicated bytes.
- iValid asserted while busy: the byte is not accepted. The upstream must hold iData and iValid until it sees oReady.
- Reset asserted mid-frame: on the next edge oTX=1 and state=IDLE. The partial frame is abandoned and oDone is not pulsed.
- Counter wrap: the bit-period counter counts 0..DIV-1 and reloads to 0. The bit index counts 0..7 and never exceeds 7.
- No parity. No glitches on oTX: it only changes at bit boundaries.

Decomposition:
- Shared package uart_pkg holds:
  - rate codes RATE_9600..RATE_115200;
  - function baud_div(clk_freq, rate) returning the rounded divisor;
  - state enum IDLE/START/DATA/STOP;
  - constant DATA_BITS=8.
- One sub-module, uart_baud_tick: a counter with sync active-low reset, an enable input and a divisor input, emitting a one-cycle tick at the end of each bit period. It is reused by the receive side.

Test Plan:
1. Reset and idle: hold reset=0 for 2 cycles, then release -> oTX=1, oBusy=0, oReady=1, oDone=0. Hold reset low mid-operation later -> same values on the next edge.
2. Single byte at 9600: iRate=0, send 0x31 -> oTX falls 1 cycle after accept. Bits sampled at mid-period are 0,1,0,0,0,1,1,0,0,1 with each bit exactly 10417 cycles. oDone pulses once at cycle 104170 after oTX falls.
3. Back-to-back at 115200: iRate=3, iValid held high with 0x32 then 0x33 -> frames 8680 cycles long with a 1-cycle high gap. oDone pulses twice and oReady is low during each frame.
4. Loopback: connect oTX to the receive path and send 0x4D, 0x35, 0x46 at 9600 -> the receiver presents 0x4D, 0x35, 0x46 in order.
5. Rate change mid-frame: send 0xA5 at iRate=1, switch iRate to 3 during DATA -> the whole frame keeps the 5208-cycle bit period. The next byte uses 868.
6. Reset mid-frame: assert reset during bit 4 of 0xFF -> oTX=1 on the next edge and there is no oDone. After release, a new 0x00 frame transmits correctly.
